// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: RV32I load/store funct3 encodings, MEM-stage FSM states
// and the alignment rule that decides whether a data-memory access may be issued.
package cpu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      case (funct3)
         F3_H, F3_HU: bad = addr_lo[0];
         F3_W:        bad = (addr_lo != 2'b00);
         default:     bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_align.sv
// Byte/halfword lane steering for the data-memory port; purely combinational.
// Stores replicate the datum across lanes with byte strobes, loads extract and extend.
module mem_align
   import cpu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic [31:0] load_data
);

   logic [31:0] shifted;

   assign shifted = rdata >> {addr_lo, 3'b000};

   always_comb begin
      wdata = store_data;
      wstrb = 4'b1111;
      case (funct3)
         F3_B: begin
            wdata = {4{store_data[7:0]}};
            wstrb = 4'b0001 << addr_lo;
         end
         F3_H: begin
            wdata = {2{store_data[15:0]}};
            wstrb = 4'b0011 << addr_lo;
         end
         default: ;
      endcase
   end

   always_comb begin
      load_data = rdata;
      case (funct3)
         F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   load_data = {24'h0, shifted[7:0]};
         F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   load_data = {16'h0, shifted[15:0]};
         default: load_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues loads/stores on a req/gnt/rvalid bus; loads stall >= 2 cycles, stores stall
// only while gnt is withheld. Stall freezes the front of the pipe; misaligned accesses are dropped.
module mem_stage
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       ex_aluOut,
   input  logic [31:0]       ex_storeData,
   input  logic              ex_memRead,
   input  logic              ex_memWrite,
   input  logic [2:0]        ex_funct3,
   input  logic              ex_writeReg,
   input  logic [4:0]        ex_rd,
   input  logic              ex_aluOut_WB_memOut,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   output logic [3:0]        dmem_wstrb,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [31:0]       dmem_rdata,
   output logic [31:0]       me_outAlu,
   output logic [31:0]       me_outMem,
   output logic              me_writeReg,
   output logic              me_aluOut_WB_memOut,
   output logic [4:0]        me_rd,
   output logic              me_stall,
   output logic              me_misalign
);

   mem_state_t  state_q, state_d;
   logic [31:0] rdata_q;
   logic        mem_op, misal, req, stall;

   assign mem_op = ex_memRead | ex_memWrite;
   assign misal  = mem_op & is_misaligned(ex_funct3, ex_aluOut[1:0]);

   always_comb begin
      state_d = state_q;
      req     = 1'b0;
      stall   = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_op && !misal) begin
               req = 1'b1;
               if (ex_memRead) begin
                  stall = 1'b1;
                  if (dmem_gnt) state_d = WAIT;
               end else begin
                  // Store retires on its grant cycle; no FSM step needed.
                  stall = !dmem_gnt;
               end
            end
         end
         WAIT: begin
            stall = 1'b1;
            if (dmem_rvalid) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == WAIT && dmem_rvalid) rdata_q <= dmem_rdata;
      end
   end

   // Reset forces the bus quiet and the stage transparent regardless of held EX/MEM contents.
   assign dmem_req    = req & !rst;
   assign dmem_we     = req & ex_memWrite & !rst;
   assign me_stall    = stall & !rst;
   assign me_misalign = misal & (state_q == IDLE) & !rst;
   assign me_writeReg = ex_writeReg & !me_stall & !me_misalign & !rst;

   assign dmem_addr           = {ex_aluOut[ADDR_W-1:2], 2'b00};
   assign me_outAlu           = ex_aluOut;
   assign me_rd               = ex_rd;
   assign me_aluOut_WB_memOut = ex_aluOut_WB_memOut;

   mem_align u_align (
      .funct3     (ex_funct3),
      .addr_lo    (ex_aluOut[1:0]),
      .store_data (ex_storeData),
      .rdata      (rdata_q),
      .wdata      (dmem_wdata),
      .wstrb      (dmem_wstrb),
      .load_data  (me_outMem)
   );

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, sitting between the EX/MEM register and the MEM/WB register. It issues loads and stores to the data memory over a request/grant/response bus and aligns byte and halfword data. It drives the `me_*` signals that the MEM/WB register captures, and stalls the front of the pipeline while a transfer is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32, data-memory address width; word-addressed alignment uses `addr[1:0]`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ex_aluOut` in 32: ALU result; the effective address for loads and stores, otherwise the writeback value.
- `ex_storeData` in 32: rs2 value for stores.
- `ex_memRead`, `ex_memWrite` in 1 each: load or store request; never both at once.
- `ex_funct3` in 3: access size and signedness (RV32I encodings).
- `ex_writeReg` in 1, `ex_rd` in 5, `ex_aluOut_WB_memOut` in 1: passed through to writeback.
- `dmem_req`, `dmem_we` out 1 each: request and write enable.
- `dmem_addr` out ADDR_W: word-aligned address, `{addr[ADDR_W-1:2], 2'b00}`.
- `dmem_wdata` out 32: write data; `dmem_wstrb` out 4: byte enables.
- `dmem_gnt` in 1: request accepted this cycle.
- `dmem_rvalid` in 1, `dmem_rdata` in 32: load response.
- `me_outAlu`, `me_outMem` out 32: ALU result and aligned load data.
- `me_writeReg`, `me_aluOut_WB_memOut` out 1, `me_rd` out 5: signals to MEM/WB.
- `me_stall` out 1: freezes PC, IF/ID, ID/EX and EX/MEM.
- `me_misalign` out 1: one-cycle flag for a misaligned access.

## Operation
- The FSM has three states: IDLE, WAIT (load granted, awaiting `rvalid`) and DONE (load data held).
- **IDLE, load:** assert `dmem_req=1`, `we=0`.
  - `me_stall=1`.
  - If `gnt` is high, go to WAIT. Otherwise stay in IDLE and keep `req` high.
- **IDLE, store:** assert `req=1`, `we=1`, `me_stall=!gnt`.
  - Stay in IDLE; the store completes on the grant cycle.
  - Data is replicated across lanes: SB `{4{b}}`, SH `{2{h}}`, SW word.
  - Strobes: SB `4'b0001<<addr[1:0]`, SH `4'b0011<<addr[1:0]`, SW `4'b1111`.
- **WAIT:** `me_stall=1` and `req=0`. On `rvalid`, capture `dmem_rdata` into `rdata_q` and go to DONE. `rvalid` is ignored in every other state.
- **DONE:** `me_stall=0`.
  - `me_outMem` is the aligned `rdata_q`, with the lane selected by `addr[1:0]`:
    - LB and LH sign-extend.
    - LBU and LHU zero-extend.
    - LW passes the word through.
  - Return to IDLE.
- **No memory operation:** stay in IDLE, `req=0`, `stall=0`. `me_outMem` takes the aligned `rdata_q` (don't-care).
- **Misaligned access:** LH/LHU/SH with `addr[0]=1`, or LW/SW with `addr[1:0]!=0`.
  - No request is issued, `me_misalign=1` and `stall=0`.
  - The FSM stays in IDLE.
- **Bubble rule:** `me_writeReg = ex_writeReg & !me_stall & !me_misalign`. MEM/WB therefore never captures a stall-cycle value with `writeReg` set.
- **Pass-through:** `me_outAlu`, `me_rd` and `me_aluOut_WB_memOut` are combinational pass-throughs of the `ex_*` inputs.

## Timing
- **Reset:** state=IDLE, `rdata_q=0`. While `rst` is high, `dmem_req=0`, `me_stall=0`, `me_writeReg=0` and `me_misalign=0`.
- **Reset mid-transaction:** an outstanding grant is abandoned. A later `rvalid` arrives in IDLE and is ignored.
- **Load, zero wait states** (`gnt` in cycle 0, `rvalid` in cycle 1):
  - Stall in cycles 0–1.
  - Data on `me_outMem` in cycle 2, captured by MEM/WB at the end of cycle 2.
- **Load, general case:** stall lasts (cycles to `gnt`) + (cycles to `rvalid`) + 1; it is never less than 2 cycles.
- **Store:** 0 stall cycles when `gnt` is high in the same cycle; 1 extra stall cycle per cycle `gnt` is withheld.
- **Held inputs:** `ex_*` stay stable while `me_stall=1`, because EX/MEM is frozen. `rdata_q` holds through DONE.
- **Back-to-back loads:** the second load's request is issued in the cycle after DONE, when the FSM is back in IDLE.

## Structure
- **Package `cpu_pkg`:**
  - funct3 constants: `F3_B=3'b000`, `F3_H=3'b001`, `F3_W=3'b010`, `F3_BU=3'b100`, `F3_HU=3'b101`.
  - FSM state enum `mem_state_t {IDLE, WAIT, DONE}`.
- **Sub-module `mem_align`:** combinational. It computes store lane replication and strobes, and load extraction and extension. It is instantiated once in `mem_stage`.

## Test plan
- **LW, zero-wait:** LW at `0x100`, `gnt` at cycle 0, `rvalid` at cycle 1 with `rdata=0xDEADBEEF` → stall at cycles 0–1; at cycle 2, `me_outMem=0xDEADBEEF`, `me_writeReg=1`.
- **LB / LBU:** `addr=0x103`, `rdata=0x80112233` → LB gives `0xFFFFFF80`; LBU gives `0x00000080`.
- **SH:** SH at `0x202`, `storeData=0x0000ABCD`, `gnt` withheld 2 cycles → `wdata=0xABCDABCD`, `wstrb=4'b1100`, `addr=0x200`; `stall` high for 2 cycles and low on the grant cycle.
- **Misaligned LW:** LW at `0x101` → `dmem_req=0`, `me_misalign=1`, `me_writeReg=0`, `stall=0`.
- **Reset in WAIT:** assert `rst` while in WAIT, release it, then pulse `rvalid` → FSM stays IDLE, `rdata_q=0`, `me_stall=0`.
